// File: rtl/cpu_pkg.sv
// Shared core definitions: control-unit op encoding, PC sequencer state and fault causes.
package cpu_pkg;

  localparam int unsigned CU_OP_W = 6;

  typedef enum logic [CU_OP_W-1:0] {
    CU_LUI   = 6'd0,
    CU_AUIPC,
    CU_JAL,
    CU_JALR,
    CU_BEQ,
    CU_BNE,
    CU_BLT,
    CU_BGE,
    CU_BLTU,
    CU_BGEU,
    CU_LB,
    CU_LH,
    CU_LW,
    CU_LBU,
    CU_LHU,
    CU_SB,
    CU_SH,
    CU_SW,
    CU_ADDI,
    CU_SLTI,
    CU_SLTIU,
    CU_XORI,
    CU_ORI,
    CU_ANDI,
    CU_SLLI,
    CU_SRLI,
    CU_SRAI,
    CU_ADD,
    CU_SUB,
    CU_SLL,
    CU_SLT,
    CU_SLTU,
    CU_XOR,
    CU_SRL,
    CU_SRA,
    CU_OR,
    CU_AND,
    CU_ERROR = 6'd38
  } cu_op_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } pc_state_t;

  localparam int unsigned FC_W = 2;
  localparam logic [FC_W-1:0] FC_NONE     = 2'b00;
  localparam logic [FC_W-1:0] FC_MISALIGN = 2'b01;
  localparam logic [FC_W-1:0] FC_ILLEGAL  = 2'b10;

endpackage

// File: rtl/pc_target.sv
// Combinational next-PC selection: branch/jump target, taken decision and alignment check.
import cpu_pkg::*;

module pc_target #(
  parameter int unsigned XLEN = 32
) (
  input  logic [CU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic               zero_i,
  input  logic               neg_i,
  output logic [XLEN-1:0]    next_pc_o,
  output logic [XLEN-1:0]    target_o,
  output logic               taken_o,
  output logic               misaligned_o
);

  cu_op_t          op;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;

  assign op = cu_op_t'(op_i);

  always_comb begin
    taken_o = 1'b0;
    case (op)
      CU_JAL, CU_JALR:  taken_o = 1'b1;
      CU_BEQ:           taken_o = zero_i;
      CU_BNE:           taken_o = ~zero_i;
      CU_BLT, CU_BLTU:  taken_o = neg_i;
      CU_BGE, CU_BGEU:  taken_o = ~neg_i | zero_i;
      default:          taken_o = 1'b0;
    endcase
  end

  // Immediates arrive in halfword units for branches/JAL; JALR drops bit 0 of the sum.
  assign br_tgt       = pc_i + (imm_i << 1);
  assign jalr_tgt     = (rs1_i + imm_i) & ~XLEN'(1);
  assign target_o     = (op == CU_JALR) ? jalr_tgt : br_tgt;
  assign next_pc_o    = taken_o ? target_o : pc_i + XLEN'(4);
  assign misaligned_o = taken_o & (target_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: registers the fetch PC, traps illegal ops and misaligned
// taken targets into a sticky FAULT state, and counts normal advances.
import cpu_pkg::*;

module pc_seq #(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] INITPC  = '0,
  parameter logic [XLEN-1:0] TRAPVEC = 'h100,
  parameter int unsigned     CNTW    = 32
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic [CU_OP_W-1:0] cuOP,
  input  logic [XLEN-1:0]    rs1Read,
  input  logic [XLEN-1:0]    signExtend,
  input  logic               Zero,
  input  logic               ALUneg,
  input  logic               iready,
  input  logic               enable,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               fault_clr,
  output logic [XLEN-1:0]    PCaddr,
  output logic [XLEN-1:0]    link_pc,
  output logic               fault,
  output logic [FC_W-1:0]    fault_cause,
  output logic [XLEN-1:0]    fault_pc,
  output logic [XLEN-1:0]    fault_addr,
  output logic [CNTW-1:0]    adv_count
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [FC_W-1:0] cause_q, cause_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] faddr_q, faddr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            misaligned;
  logic            adv;
  logic            illegal;

  pc_target #(.XLEN(XLEN)) u_target (
    .op_i         (cuOP),
    .pc_i         (pc_q),
    .rs1_i        (rs1Read),
    .imm_i        (signExtend),
    .zero_i       (Zero),
    .neg_i        (ALUneg),
    .next_pc_o    (next_pc),
    .target_o     (target),
    .taken_o      (taken),
    .misaligned_o (misaligned)
  );

  assign adv     = iready & enable;
  assign illegal = (cuOP >= CU_ERROR);

  // State and datapath registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= INITPC;
      cause_q <= FC_NONE;
      fpc_q   <= '0;
      faddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      fpc_q   <= fpc_d;
      faddr_q <= faddr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: redirect always returns to RUN
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (adv && (illegal || misaligned)) state_d = FAULT;
        FAULT:   if (fault_clr) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Next PC, fault capture and advance counter
  always_comb begin
    pc_d    = pc_q;
    cause_d = cause_q;
    fpc_d   = fpc_q;
    faddr_d = faddr_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      pc_d    = redirect_pc & ~XLEN'(3);
      cause_d = FC_NONE;
      fpc_d   = '0;
      faddr_d = '0;
    end else if (state_q == FAULT) begin
      if (fault_clr) begin
        cause_d = FC_NONE;
        fpc_d   = '0;
        faddr_d = '0;
      end
    end else if (adv) begin
      if (illegal) begin
        pc_d    = TRAPVEC;
        cause_d = FC_ILLEGAL;
        fpc_d   = pc_q;
        faddr_d = '0;
      end else if (misaligned) begin
        pc_d    = TRAPVEC;
        cause_d = FC_MISALIGN;
        fpc_d   = pc_q;
        faddr_d = target;
      end else begin
        pc_d  = next_pc;
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  assign PCaddr      = pc_q;
  assign link_pc     = pc_q + XLEN'(4);
  assign fault       = (state_q == FAULT);
  assign fault_cause = cause_q;
  assign fault_pc    = fpc_q;
  assign fault_addr  = faddr_q;
  assign adv_count   = cnt_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the sequencing and fault rules.
module tb_pc_seq;

  localparam int unsigned   XLEN    = 32;
  localparam logic [31:0]   INITPC  = 32'h0;
  localparam logic [31:0]   TRAPVEC = 32'h100;
  localparam int unsigned   CNTW    = 4;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [5:0]  cuOP = 6'd0;
  logic [31:0] rs1Read = '0;
  logic [31:0] signExtend = '0;
  logic        Zero = 1'b0;
  logic        ALUneg = 1'b0;
  logic        iready = 1'b0;
  logic        enable = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fault_clr = 1'b0;
  logic [31:0] PCaddr;
  logic [31:0] link_pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] fault_addr;
  logic [3:0]  adv_count;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  // model state
  logic [31:0] m_pc;
  bit          m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_fpc;
  logic [31:0] m_faddr;
  int          m_cnt;

  pc_seq #(.XLEN(XLEN), .INITPC(INITPC), .TRAPVEC(TRAPVEC), .CNTW(CNTW)) dut (
    .clk(clk), .nRST(nRST), .cuOP(cuOP), .rs1Read(rs1Read), .signExtend(signExtend),
    .Zero(Zero), .ALUneg(ALUneg), .iready(iready), .enable(enable),
    .redirect(redirect), .redirect_pc(redirect_pc), .fault_clr(fault_clr),
    .PCaddr(PCaddr), .link_pc(link_pc), .fault(fault), .fault_cause(fault_cause),
    .fault_pc(fault_pc), .fault_addr(fault_addr), .adv_count(adv_count)
  );

  always #5 clk = ~clk;

  function automatic bit exp_taken(int op, bit z, bit n);
    case (op)
      2, 3:    return 1'b1;
      4:       return z;
      5:       return !z;
      6, 8:    return n;
      7, 9:    return !n || z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_tgt(int op, logic [31:0] pc, logic [31:0] rs1,
                                          logic [31:0] imm);
    if (op == 3) return (rs1 + imm) & ~32'h1;
    return pc + imm * 2;
  endfunction

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      m_pc <= INITPC; m_fault <= 1'b0; m_cause <= 2'd0;
      m_fpc <= '0; m_faddr <= '0; m_cnt <= 0;
    end else if (redirect) begin
      m_pc <= redirect_pc & ~32'h3; m_fault <= 1'b0; m_cause <= 2'd0;
      m_fpc <= '0; m_faddr <= '0;
    end else if (m_fault) begin
      if (fault_clr) begin
        m_fault <= 1'b0; m_cause <= 2'd0; m_fpc <= '0; m_faddr <= '0;
      end
    end else if (iready && enable) begin
      if (int'(cuOP) >= 38) begin
        m_pc <= TRAPVEC; m_fault <= 1'b1; m_cause <= 2'd2; m_fpc <= m_pc; m_faddr <= '0;
      end else if (exp_taken(int'(cuOP), Zero, ALUneg) &&
                   (exp_tgt(int'(cuOP), m_pc, rs1Read, signExtend) % 4 != 0)) begin
        m_pc <= TRAPVEC; m_fault <= 1'b1; m_cause <= 2'd1; m_fpc <= m_pc;
        m_faddr <= exp_tgt(int'(cuOP), m_pc, rs1Read, signExtend);
      end else begin
        m_pc <= exp_taken(int'(cuOP), Zero, ALUneg) ?
                exp_tgt(int'(cuOP), m_pc, rs1Read, signExtend) : m_pc + 32'd4;
        m_cnt <= (m_cnt + 1) % 16;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("PCaddr", PCaddr, m_pc);
      chk("link_pc", link_pc, m_pc + 32'd4);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fault_cause", 32'(fault_cause), 32'(m_cause));
      chk("fault_pc", fault_pc, m_fpc);
      chk("fault_addr", fault_addr, m_faddr);
      chk("adv_count", 32'(adv_count), 32'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_pc", PCaddr, 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    chk("reset_cnt", 32'(adv_count), 32'h0);
    nRST = 1'b1;
    cmp_on = 1'b1;

    // sequential advance
    cuOP = 6'd27; iready = 1'b1; enable = 1'b1;
    repeat (3) cyc();
    chk("seq_pc", PCaddr, 32'hC);
    chk("seq_cnt", 32'(adv_count), 32'd3);

    // BEQ taken / not taken from 0x10
    redirect = 1'b1; redirect_pc = 32'h10; cyc(); redirect = 1'b0;
    cuOP = 6'd4; signExtend = 32'd8; Zero = 1'b1; cyc();
    chk("beq_taken", PCaddr, 32'h20);
    redirect = 1'b1; cyc(); redirect = 1'b0;
    Zero = 1'b0; cyc();
    chk("beq_untaken", PCaddr, 32'h14);

    // misaligned JALR
    cuOP = 6'd3; rs1Read = 32'h101; signExtend = 32'd2; cyc();
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_cause", 32'(fault_cause), 32'h1);
    chk("mis_addr", fault_addr, 32'h102);
    chk("mis_fpc", fault_pc, 32'h14);
    chk("mis_pc", PCaddr, 32'h100);
    chk("mis_cnt", 32'(adv_count), 32'd5);

    // FAULT is sticky until fault_clr
    cuOP = 6'd2;
    for (int i = 0; i < 5; i++) begin
      iready = 1'($urandom_range(0, 1)); enable = 1'($urandom_range(0, 1)); cyc();
    end
    chk("hold_pc", PCaddr, 32'h100);
    chk("hold_fault", 32'(fault), 32'h1);
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0;
    chk("clr_fault", 32'(fault), 32'h0);
    chk("clr_pc", PCaddr, 32'h100);
    cuOP = 6'd27; iready = 1'b1; enable = 1'b1; cyc();
    chk("after_clr_pc", PCaddr, 32'h104);

    // illegal op, then redirect with simultaneous fault_clr
    redirect = 1'b1; redirect_pc = 32'h40; cyc(); redirect = 1'b0;
    cuOP = 6'd38; cyc();
    chk("ill_cause", 32'(fault_cause), 32'h2);
    chk("ill_fpc", fault_pc, 32'h40);
    chk("ill_pc", PCaddr, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h203; fault_clr = 1'b1; cyc();
    redirect = 1'b0; fault_clr = 1'b0;
    chk("redir_pc", PCaddr, 32'h200);
    chk("redir_fault", 32'(fault), 32'h0);
    chk("redir_cause", 32'(fault_cause), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)      cuOP = 6'($urandom_range(0, 9));
      else if (r < 8) cuOP = 6'($urandom_range(10, 37));
      else            cuOP = 6'($urandom_range(0, 63));
      signExtend  = 32'(int'($urandom_range(0, 63)) - 32);
      rs1Read     = $urandom;
      Zero        = 1'($urandom_range(0, 1));
      ALUneg      = 1'($urandom_range(0, 1));
      iready      = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 3) != 0);
      fault_clr   = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      cyc();
    end
    redirect = 1'b0; fault_clr = 1'b0;

    // counter wrap, then asynchronous reset mid-cycle
    nRST = 1'b0; cyc(); nRST = 1'b1;
    cuOP = 6'd27; iready = 1'b1; enable = 1'b1;
    repeat (16) cyc();
    chk("wrap_cnt", 32'(adv_count), 32'h0);
    chk("wrap_pc", PCaddr, 32'h40);
    #2 nRST = 1'b0;
    #1;
    chk("async_pc", PCaddr, INITPC);
    chk("async_cnt", 32'(adv_count), 32'h0);
    #10 nRST = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the single-issue RISC-V core; the successor to the current fixed 32-bit PC register. It computes and registers the next fetch address from the decoded control-unit op, branch flags and immediate. Over the current PC it adds configurable width, a JALR bit-0 clear and a redirect port. It also adds misaligned-target and illegal-op fault handling with a sticky fault state, plus a retired-advance counter. It sits between the control unit/ALU and the instruction-fetch interface.

## Interface
- `XLEN`, 32, address/data width (≥ 8)
- `INITPC`, 0, PC value loaded on reset
- `TRAPVEC`, 32'h0000_0100, PC loaded on fault entry (`XLEN` bits, bits [1:0] must be 0)
- `CNTW`, 32, width of advance counter
- `clk` in 1 — rising-edge clock
- `nRST` in 1 — asynchronous, active-low reset
- `cuOP` in 6 — decoded op, `cu_op_t` encoding
- `rs1Read` in XLEN — rs1 value (JALR base)
- `signExtend` in XLEN — sign-extended immediate
- `Zero` in 1 — ALU result zero
- `ALUneg` in 1 — ALU result negative / less-than
- `iready` in 1 — instruction fetch complete
- `enable` in 1 — core-level advance permit
- `redirect` in 1 — external PC load request
- `redirect_pc` in XLEN — redirect target; bits [1:0] forced to 0
- `fault_clr` in 1 — acknowledge and leave FAULT
- `PCaddr` out XLEN — current PC (registered)
- `link_pc` out XLEN — PCaddr + 4, combinational
- `fault` out 1 — high while in FAULT
- `fault_cause` out 2 — 00 none, 01 misaligned target, 10 illegal op
- `fault_pc` out XLEN — PC of faulting instruction
- `fault_addr` out XLEN — offending target (misaligned) or 0 (illegal)
- `adv_count` out CNTW — number of normal advances

## Operation
- States: RUN, FAULT. Reset → RUN. Reset values:
  - PCaddr = INITPC
  - fault = 0, fault_cause = 0, fault_pc = 0, fault_addr = 0
  - adv_count = 0
- Target rules (all arithmetic mod 2^XLEN):
  - branch/JAL target = PCaddr + (signExtend << 1)
  - JALR target = (rs1Read + signExtend) with bit 0 cleared
  - sequential = PCaddr + 4
- Taken conditions:
  - JAL, JALR always
  - BEQ: Zero
  - BNE: ~Zero
  - BLT/BLTU: ALUneg
  - BGE/BGEU: ~ALUneg | Zero
  - all other ops: sequential
- Priority per cycle, highest first:
  1. redirect (either state): PC ← redirect_pc & ~3. State → RUN, fault fields cleared, adv_count unchanged.
  2. FAULT: PC held. On fault_clr, state → RUN and fault fields cleared; PC stays TRAPVEC.
  3. RUN, `iready & enable`, cuOP == CU_ERROR (or any encoding > CU_ERROR): PC ← TRAPVEC, state → FAULT, cause 10, fault_pc ← PCaddr, fault_addr ← 0.
  4. RUN, `iready & enable`, taken target with bits [1:0] ≠ 0: PC ← TRAPVEC, state → FAULT, cause 01, fault_pc ← PCaddr, fault_addr ← target.
  5. RUN, `iready & enable`: PC ← selected next PC, adv_count += 1 (wraps).
  6. Otherwise: hold.
- Untaken branches never fault, whatever the target alignment.
- Faulting cycles do not increment adv_count.

## Timing
- Next PC is combinational from inputs; PCaddr updates on the rising clk edge following a qualifying cycle, so 1-cycle latency.
- fault and fault_cause rise in the same edge that loads TRAPVEC. They stay high until the edge on which fault_clr or redirect is sampled.
- A fault_clr asserted while in RUN is ignored.
- redirect and fault_clr asserted together: the redirect action applies.
- Asserting nRST low mid-operation immediately forces all reset values, asynchronously, including while in FAULT.
- adv_count wraps from 2^CNTW−1 to 0 with no flag.

## Structure
- Shared package `cpu_pkg` holds:
  - `cu_op_t`, 6-bit enum: CU_LUI=0, CU_AUIPC, CU_JAL, CU_JALR, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU, loads, stores, immediate ALU, register ALU, CU_ERROR=38
  - `pc_state_t` {RUN, FAULT}
  - fault-cause constants
- One sub-module: `pc_target`, combinational. It produces the next PC, a taken flag and a misaligned flag from cuOP, PCaddr, rs1Read, signExtend, Zero and ALUneg.
- The state register, fault capture and counter live in pc_seq.

## Test plan
- Reset with INITPC=0; hold iready=enable=1 with cuOP=CU_ADD for 3 cycles → PCaddr 0→4→8→C, adv_count=3.
- PC=0x10, CU_BEQ, signExtend=8, Zero=1 → PC=0x20. Repeat with Zero=0 → PC=0x14.
- CU_JALR, rs1Read=0x101, signExtend=2 → PC=0x102. This is misaligned, so: fault=1, cause=01, fault_addr=0x102, PC=TRAPVEC=0x100, adv_count unchanged.
- In FAULT, toggle iready/enable with CU_JAL for 5 cycles → PC stays 0x100. Then pulse fault_clr → fault=0 next edge, next CU_ADD gives PC 0x104.
- CU_ERROR at PC=0x40 → cause=10, fault_pc=0x40. Then assert redirect=1 with redirect_pc=0x203 and fault_clr=1 together → PC=0x200, RUN, fault fields 0.
- With CNTW=4, advance 16 times → adv_count back to 0. Then drop nRST mid-cycle → PCaddr=INITPC immediately, before the next clk edge.
